// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, legality helper and FSM state type for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, RMW} lsu_state_t;

  // Stores only know B/H/W; loads additionally have BU/HU.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    if (we)
      return funct3 > F3_W;
    return funct3 != F3_B && funct3 != F3_H && funct3 != F3_W &&
           funct3 != F3_BU && funct3 != F3_HU;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends a load lane from a memory word, and merges a
// store lane into the old word for read-modify-write. No state, no backpressure.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word_in,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [31:0] lane;
  logic [31:0] mask;

  always_comb begin
    shamt     = {offset, 3'b000};
    lane      = word_in >> shamt;
    load_data = lane;
    mask      = 32'hFFFF_FFFF;
    case (funct3[1:0])
      F3_B[1:0]: begin
        load_data = funct3[2] ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        mask      = 32'h0000_00FF << shamt;
      end
      F3_H[1:0]: begin
        load_data = funct3[2] ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
        mask      = 32'h0000_FFFF << shamt;
      end
      default: ;
    endcase
    merged = (word_in & ~mask) | ((store_data << shamt) & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store stage: loads and SW respond 1 cycle after accept; SB/SH read-modify-write and respond
// after 2 (req_ready low during the write cycle). MISALIGN_TRAP_EN faults misaligned/illegal requests.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int size = 1024,
  parameter int bits = $clog2(size)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  output logic [bits-1:0] mem_address,
  output logic            mem_read_enable,
  output logic            mem_write_enable,
  output logic [31:0]     mem_input_data,
  input  logic [31:0]     mem_output_data
);

  lsu_state_t      state;
  logic [bits-1:0] rmw_index;
  logic [31:0]     rmw_data;
  logic            accept;
  logic            illegal;
  logic            fault;
  logic [2:0]      f3;
  logic [1:0]      offset;
  logic            is_load;
  logic            is_word_store;
  logic            is_sub_store;
  logic [31:0]     load_data;
  logic [31:0]     merged;
  logic            unused_addr_bits;

  // Address bits above the word index are ignored so accesses wrap modulo size.
  assign unused_addr_bits = &{1'b0, req_addr[31:bits+2]};

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign illegal   = is_illegal(req_we, req_funct3);
  assign f3        = illegal ? F3_W : req_funct3;

  // Sub-word offsets are forced to the natural alignment of the access size.
  always_comb begin
    offset = 2'b00;
    case (f3[1:0])
      F3_B[1:0]: offset = req_addr[1:0];
      F3_H[1:0]: offset = {req_addr[1], 1'b0};
      default:   offset = 2'b00;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign fault = illegal ||
                 (f3[1:0] == F3_H[1:0] && req_addr[0]) ||
                 (f3[1:0] == F3_W[1:0] && req_addr[1:0] != 2'b00);
`else
  assign fault = 1'b0;
`endif

  assign is_load       = accept && !req_we && !fault;
  assign is_word_store = accept && req_we && !fault && f3[1:0] == F3_W[1:0];
  assign is_sub_store  = accept && req_we && !fault && f3[1:0] != F3_W[1:0];

  lsu_align u_align (
    .funct3     (f3),
    .offset     (offset),
    .word_in    (mem_output_data),
    .store_data (req_wdata),
    .load_data  (load_data),
    .merged     (merged)
  );

  assign mem_address      = (state == RMW) ? rmw_index : req_addr[bits+1:2];
  assign mem_input_data   = (state == RMW) ? rmw_data : req_wdata;
  assign mem_read_enable  = is_load || is_sub_store;
  assign mem_write_enable = (state == RMW) || is_word_store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      rmw_index <= '0;
      rmw_data  <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (is_sub_store) begin
            state     <= RMW;
            rmw_index <= req_addr[bits+1:2];
            rmw_data  <= merged;
          end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= fault;
            rsp_rdata <= is_load ? load_data : 32'd0;
          end
        end
        RMW: begin
          state     <= IDLE;
          rsp_valid <= 1'b1;
          rsp_rdata <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
